// File: rtl/not_gate_bist_checker.sv
// Built-in self-test controller for one inverter: it drives alternating vectors
// onto the gate input, lets them settle, checks for the inverse and reports the result.
module not_gate_bist_checker #(
    parameter int NUM_VECTORS   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8,
    parameter int IDX_W         = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             gate_out,
    output logic             gate_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    state_t             state_q, state_d;
    logic               gate_in_q, gate_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               mismatch;

    // Only a clean 0/1 inverse counts as a match, so X/Z on gate_out falls to mismatch.
    always_comb begin
        mismatch = 1'b1;
        if (gate_out ^ gate_in_q) begin
            mismatch = 1'b0;
        end
    end

    always_comb begin
        state_d         = state_q;
        gate_in_d       = gate_in_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        vec_idx_d       = vec_idx_q;
        settle_cnt_d    = settle_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d         = DRIVE;
                    err_count_d     = '0;
                    first_err_idx_d = '0;
                    vec_idx_d       = '0;
                end
            end
            DRIVE: begin
                gate_in_d    = vec_idx_q[0];
                settle_cnt_d = SETTLE_INIT;
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    if (err_count_q == '0) begin
                        first_err_idx_d = vec_idx_q;
                    end
                end
                if (vec_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    vec_idx_d = vec_idx_q + 1'b1;
                    state_d   = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_count_d == '0);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q         <= IDLE;
            gate_in_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            vec_idx_q       <= '0;
            settle_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            gate_in_q       <= gate_in_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            vec_idx_q       <= vec_idx_d;
            settle_cnt_q    <= settle_cnt_d;
        end
    end

    assign gate_in       = gate_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_not_gate_bist_checker.sv
// Bench for not_gate_bist_checker: four instances with different parameters and
// behavioural gate models, checked against expected results queued at each start.
module tb_not_gate_bist_checker;

    typedef struct {
        int lat;
        int err;
        int fidx;
        bit pas;
    } exp_t;

    logic clk;
    logic reset_L;
    logic [3:0] start;
    int   mode0;
    int   sel;
    int   n_cmp;
    int   n_err;

    exp_t res_q[$];
    bit   gin_q[$];

    // instance 0: defaults, selectable gate model
    logic       gin0, gout0, busy0, done0, pass0;
    logic [7:0] err0, fidx0;
    // instance 1: 6 vectors, 2-bit saturating counter, buffer fault
    logic       gin1, gout1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [7:0] fidx1;
    // instances 2/3: one vector, inverter output delayed two clocks
    logic       gin2, gout2, busy2, done2, pass2;
    logic [7:0] err2, fidx2;
    logic       gin3, gout3, busy3, done3, pass3;
    logic [7:0] err3, fidx3;
    logic       arm2, d2a, d2b, arm3, d3a, d3b;

    logic        mbusy, mdone, mpass, mgin;
    logic [7:0]  merr, mfidx;

    not_gate_bist_checker u0 (
        .clk(clk), .reset_L(reset_L), .start(start[0]), .gate_out(gout0),
        .gate_in(gin0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_idx(fidx0)
    );

    not_gate_bist_checker #(.NUM_VECTORS(6), .ERR_W(2)) u1 (
        .clk(clk), .reset_L(reset_L), .start(start[1]), .gate_out(gout1),
        .gate_in(gin1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_idx(fidx1)
    );

    not_gate_bist_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(1)) u2 (
        .clk(clk), .reset_L(reset_L), .start(start[2]), .gate_out(gout2),
        .gate_in(gin2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(fidx2)
    );

    not_gate_bist_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(3)) u3 (
        .clk(clk), .reset_L(reset_L), .start(start[3]), .gate_out(gout3),
        .gate_in(gin3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_idx(fidx3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        case (mode0)
            0:       gout0 = ~gin0;
            1:       gout0 = 1'b0;
            default: gout0 = gin0;
        endcase
    end

    assign gout1 = gin1;

    // The delay line only starts carrying the inverse once the run has begun driving.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            arm2 <= 1'b0; d2a <= 1'b0; d2b <= 1'b0;
            arm3 <= 1'b0; d3a <= 1'b0; d3b <= 1'b0;
        end else begin
            arm2 <= busy2; d2a <= arm2 ? ~gin2 : 1'b0; d2b <= d2a;
            arm3 <= busy3; d3a <= arm3 ? ~gin3 : 1'b0; d3b <= d3a;
        end
    end
    assign gout2 = d2b;
    assign gout3 = d3b;

    always_comb begin
        mbusy = busy0; mdone = done0; mpass = pass0; mgin = gin0; merr = err0; mfidx = fidx0;
        case (sel)
            1: begin mbusy = busy1; mdone = done1; mpass = pass1; mgin = gin1; merr = {6'b0, err1}; mfidx = fidx1; end
            2: begin mbusy = busy2; mdone = done2; mpass = pass2; mgin = gin2; merr = err2; mfidx = fidx2; end
            3: begin mbusy = busy3; mdone = done3; mpass = pass3; mgin = gin3; merr = err3; mfidx = fidx3; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
            $error("check %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string tag, input int sel_i, input bit hold,
                            input int lat, input int err, input int fidx, input bit pas);
        exp_t r;
        int   got;
        sel = sel_i;
        res_q.push_back('{lat, err, fidx, pas});
        if (sel_i == 0) begin
            for (int k = 0; k < 4; k++) gin_q.push_back(k[0]);
        end
        @(negedge clk);
        start[sel_i] = 1'b1;
        tick();
        if (!hold) start[sel_i] = 1'b0;
        chk({tag, "_busy_at_start"}, {31'b0, mbusy}, 32'd1);
        chk({tag, "_err_cleared"}, {24'b0, merr}, 32'd0);
        chk({tag, "_done_low"}, {31'b0, mdone}, 32'd0);
        got = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (sel_i == 0 && (n % 4) == 1 && gin_q.size() > 0) begin
                chk({tag, "_gate_in"}, {31'b0, mgin}, {31'b0, gin_q.pop_front()});
            end
            if (mdone === 1'b1) begin
                got = n;
                break;
            end
        end
        start[sel_i] = 1'b0;
        r = res_q.pop_front();
        chk({tag, "_latency"}, got, r.lat);
        chk({tag, "_err_count"}, {24'b0, merr}, r.err);
        chk({tag, "_first_err_idx"}, {24'b0, mfidx}, r.fidx);
        chk({tag, "_pass"}, {31'b0, mpass}, {31'b0, r.pas});
        chk({tag, "_busy_done"}, {31'b0, mbusy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        sel     = 0;
        mode0   = 0;
        start   = 4'b0;
        reset_L = 1'b0;
        tick();
        tick();
        chk("rst_gate_in", {31'b0, gin0}, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_done", {31'b0, done0}, 32'd0);
        chk("rst_pass", {31'b0, pass0}, 32'd0);
        chk("rst_err", {24'b0, err0}, 32'd0);
        chk("rst_fidx", {24'b0, fidx0}, 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        tick();

        mode0 = 0;
        run_case("good", 0, 1'b0, 16, 0, 0, 1'b1);
        mode0 = 1;
        run_case("tied0", 0, 1'b0, 16, 2, 0, 1'b0);
        mode0 = 2;
        run_case("buffer", 0, 1'b0, 16, 4, 0, 1'b0);

        mode0 = 1;
        run_case("hold", 0, 1'b1, 16, 2, 0, 1'b0);
        repeat (3) tick();
        chk("hold_done_kept", {31'b0, done0}, 32'd1);
        chk("hold_no_rerun", {31'b0, busy0}, 32'd0);
        mode0 = 0;
        run_case("restart", 0, 1'b0, 16, 0, 0, 1'b1);

        mode0 = 2;
        sel   = 0;
        @(negedge clk);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int n = 1; n <= 10; n++) tick();
        chk("mid_busy", {31'b0, busy0}, 32'd1);
        chk("mid_err", {24'b0, err0}, 32'd2);
        #2 reset_L = 1'b0;
        #1;
        chk("async_busy", {31'b0, busy0}, 32'd0);
        chk("async_err", {24'b0, err0}, 32'd0);
        chk("async_gate_in", {31'b0, gin0}, 32'd0);
        chk("async_done", {31'b0, done0}, 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (4) tick();
        chk("post_rst_busy", {31'b0, busy0}, 32'd0);
        chk("post_rst_done", {31'b0, done0}, 32'd0);
        chk("post_rst_pass", {31'b0, pass0}, 32'd0);

        run_case("saturate", 1, 1'b0, 24, 3, 0, 1'b0);
        run_case("stale_s1", 2, 1'b0, 3, 1, 0, 1'b0);
        run_case("settled_s3", 3, 1'b0, 5, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
